// File: rtl/register_file_sb.sv
// DLX register file: two combinational read ports, one write port, and a per-register
// busy scoreboard that lets decode stall on results still in flight.
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadAddr1,
    input  logic [ADDR_WIDTH-1:0] ReadAddr2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  Busy1,
    output logic                  Busy2,
    input  logic [ADDR_WIDTH-1:0] WriteAddr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] ReserveAddr,
    input  logic                  Reserve,
    output logic [ADDR_WIDTH:0]   BusyCount
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regFile [DEPTH];
    logic [DEPTH-1:0]      busyReg;
    logic [DEPTH-1:0]      busyNext;
    logic                  writeAllowed;

    logic [ADDR_WIDTH-1:0] portAddr [2];
    logic [DATA_WIDTH-1:0] portData [2];
    logic                  portBusy [2];

    function automatic logic [ADDR_WIDTH:0] countOnes(input logic [DEPTH-1:0] v);
        logic [ADDR_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_WIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign writeAllowed = RegWrite && !(ZERO_REG != 0 && WriteAddr == '0);

    // Per-register scoreboard update: a new reservation supersedes a same-edge release.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
        logic setBit;
        logic clrBit;
        assign setBit = Reserve && ReserveAddr == ADDR_WIDTH'(gi) && !(ZERO_REG != 0 && gi == 0);
        assign clrBit = RegWrite && WriteAddr == ADDR_WIDTH'(gi);
        assign busyNext[gi] = setBit | (busyReg[gi] & ~clrBit);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile[i] <= (INIT_INDEX != 0) ? DATA_WIDTH'(i) : '0;
            end
            busyReg <= '0;
        end else begin
            if (writeAllowed) begin
                regFile[WriteAddr] <= WriteData;
            end
            busyReg <= busyNext;
        end
    end

    assign BusyCount = countOnes(busyReg);

    assign portAddr[0] = ReadAddr1;
    assign portAddr[1] = ReadAddr2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        always_comb begin
            portData[gi] = regFile[portAddr[gi]];
            if (BYPASS != 0 && writeAllowed && WriteAddr == portAddr[gi]) begin
                portData[gi] = WriteData;
            end
            if (ZERO_REG != 0 && portAddr[gi] == '0) begin
                portData[gi] = '0;
            end
        end

        // A value being forwarded this cycle is no longer pending, unless it is re-reserved.
        always_comb begin
            portBusy[gi] = busyReg[portAddr[gi]];
            if (BYPASS != 0 && RegWrite && WriteAddr == portAddr[gi]
                && !(Reserve && ReserveAddr == portAddr[gi])) begin
                portBusy[gi] = 1'b0;
            end
        end
    end

    assign ReadData1 = portData[0];
    assign ReadData2 = portData[1];
    assign Busy1     = portBusy[0];
    assign Busy2     = portBusy[1];
endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: a vector table for single-cycle behaviour plus a
// hand-written asynchronous-reset sequence; a BYPASS=0 copy checks the non-forwarding read.
module tb_register_file_sb;
    logic        Clock;
    logic        Reset;
    logic [4:0]  ReadAddr1, ReadAddr2, WriteAddr, ReserveAddr;
    logic [31:0] WriteData;
    logic        RegWrite, Reserve;
    logic [31:0] ReadData1, ReadData2, nbReadData1, nbReadData2;
    logic        Busy1, Busy2, nbBusy1, nbBusy2;
    logic [5:0]  BusyCount, nbBusyCount;

    int checks = 0;
    int errors = 0;

    register_file_sb dut (
        .Clock(Clock), .Reset(Reset),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Busy1(Busy1), .Busy2(Busy2),
        .WriteAddr(WriteAddr), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReserveAddr(ReserveAddr), .Reserve(Reserve),
        .BusyCount(BusyCount)
    );

    register_file_sb #(.BYPASS(0)) dutNb (
        .Clock(Clock), .Reset(Reset),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .ReadData1(nbReadData1), .ReadData2(nbReadData2),
        .Busy1(nbBusy1), .Busy2(nbBusy2),
        .WriteAddr(WriteAddr), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReserveAddr(ReserveAddr), .Reserve(Reserve),
        .BusyCount(nbBusyCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        we;
        logic [4:0]  rsa;
        logic        rs;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic [5:0]  ecnt;
        logic        chkNb;
        logic [31:0] eNb;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        RegWrite = 1'b0; Reserve = 1'b0;
        WriteAddr = 5'd0; WriteData = 32'd0; ReserveAddr = 5'd0;
    endtask

    initial begin
        vecs[0]  = '{5'd7,  5'd31, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'd7,        32'd31,       1'b0, 1'b0, 6'd0, 1'b0, 32'd0};
        vecs[1]  = '{5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 1'b1, 5'd0,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0, 1'b1, 32'd5};
        vecs[2]  = '{5'd5,  5'd6,  5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'd6,        1'b0, 1'b0, 6'd0, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{5'd0,  5'd0,  5'd0,  32'h1234,     1'b1, 5'd0,  1'b1, 32'd0,        32'd0,        1'b0, 1'b0, 6'd0, 1'b0, 32'd0};
        vecs[4]  = '{5'd0,  5'd1,  5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'd0,        32'd1,        1'b0, 1'b0, 6'd0, 1'b0, 32'd0};
        vecs[5]  = '{5'd3,  5'd4,  5'd0,  32'h0,        1'b0, 5'd3,  1'b1, 32'd3,        32'd4,        1'b0, 1'b0, 6'd0, 1'b0, 32'd0};
        vecs[6]  = '{5'd3,  5'd3,  5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'd3,        32'd3,        1'b1, 1'b1, 6'd1, 1'b0, 32'd0};
        vecs[7]  = '{5'd3,  5'd2,  5'd3,  32'h42,       1'b1, 5'd0,  1'b0, 32'h42,       32'd2,        1'b0, 1'b0, 6'd1, 1'b0, 32'd0};
        vecs[8]  = '{5'd3,  5'd3,  5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h42,       32'h42,       1'b0, 1'b0, 6'd0, 1'b0, 32'd0};
        vecs[9]  = '{5'd9,  5'd3,  5'd9,  32'hAAAA5555, 1'b1, 5'd9,  1'b1, 32'hAAAA5555, 32'h42,       1'b0, 1'b0, 6'd0, 1'b0, 32'd0};
        vecs[10] = '{5'd9,  5'd9,  5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'hAAAA5555, 32'hAAAA5555, 1'b1, 1'b1, 6'd1, 1'b0, 32'd0};
        vecs[11] = '{5'd10, 5'd11, 5'd11, 32'h11,       1'b1, 5'd10, 1'b1, 32'd10,       32'h11,       1'b0, 1'b0, 6'd1, 1'b0, 32'd0};
        vecs[12] = '{5'd10, 5'd11, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'd10,       32'h11,       1'b1, 1'b0, 6'd2, 1'b0, 32'd0};
        vecs[13] = '{5'd10, 5'd9,  5'd0,  32'h0,        1'b0, 5'd10, 1'b1, 32'd10,       32'hAAAA5555, 1'b1, 1'b1, 6'd2, 1'b0, 32'd0};
        vecs[14] = '{5'd10, 5'd9,  5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'd10,       32'hAAAA5555, 1'b1, 1'b1, 6'd2, 1'b0, 32'd0};

        idle();
        ReadAddr1 = 5'd0; ReadAddr2 = 5'd0;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;

        // Inputs settle just after an edge, outputs are sampled mid-cycle before the next edge.
        for (int i = 0; i < 15; i++) begin
            ReadAddr1 = vecs[i].ra1; ReadAddr2 = vecs[i].ra2;
            WriteAddr = vecs[i].wa;  WriteData = vecs[i].wd; RegWrite = vecs[i].we;
            ReserveAddr = vecs[i].rsa; Reserve = vecs[i].rs;
            #4;
            check($sformatf("v%0d ReadData1", i), ReadData1, vecs[i].e1);
            check($sformatf("v%0d ReadData2", i), ReadData2, vecs[i].e2);
            check($sformatf("v%0d Busy1", i), {31'd0, Busy1}, {31'd0, vecs[i].eb1});
            check($sformatf("v%0d Busy2", i), {31'd0, Busy2}, {31'd0, vecs[i].eb2});
            check($sformatf("v%0d BusyCount", i), {26'd0, BusyCount}, {26'd0, vecs[i].ecnt});
            if (vecs[i].chkNb) begin
                check($sformatf("v%0d nobypass ReadData1", i), nbReadData1, vecs[i].eNb);
            end
            $display("vec %0d: ra=%0d/%0d rd=0x%08h/0x%08h busy=%0b%0b cnt=%0d",
                     i, ReadAddr1, ReadAddr2, ReadData1, ReadData2, Busy1, Busy2, BusyCount);
            @(posedge Clock);
            #1;
        end

        // Asynchronous reset between edges with reservations outstanding and a write pending.
        idle();
        Reset = 1'b1;
        #2 Reset = 1'b0;
        @(posedge Clock);
        #1;
        for (int k = 1; k <= 4; k++) begin
            ReserveAddr = 5'(k); Reserve = 1'b1;
            @(posedge Clock);
            #1;
        end
        Reserve = 1'b0;
        ReadAddr1 = 5'd1; ReadAddr2 = 5'd4;
        #1;
        check("pre-reset BusyCount", {26'd0, BusyCount}, 32'd4);
        check("pre-reset Busy1", {31'd0, Busy1}, 32'd1);
        check("pre-reset Busy2", {31'd0, Busy2}, 32'd1);
        $display("reserve r1..r4: cnt=%0d busy=%0b%0b", BusyCount, Busy1, Busy2);
        RegWrite = 1'b1; WriteAddr = 5'd2; WriteData = 32'h0000FFFF;
        #1 Reset = 1'b1;
        #1;
        check("async BusyCount", {26'd0, BusyCount}, 32'd0);
        check("async Busy1", {31'd0, Busy1}, 32'd0);
        check("async Busy2", {31'd0, Busy2}, 32'd0);
        check("async ReadData1 r1", ReadData1, 32'd1);
        check("async ReadData2 r4", ReadData2, 32'd4);
        ReadAddr1 = 5'd3;
        #1 check("async ReadData1 r3", ReadData1, 32'd3);
        $display("async reset: cnt=%0d rd=0x%08h/0x%08h", BusyCount, ReadData1, ReadData2);
        @(posedge Clock);
        #1;
        idle();
        Reset = 1'b0;
        ReadAddr1 = 5'd2; ReadAddr2 = 5'd0;
        #2;
        check("dropped write r2", ReadData1, 32'd2);
        check("post-reset r0", ReadData2, 32'd0);
        check("post-reset BusyCount", {26'd0, BusyCount}, 32'd0);
        $display("after reset: r2=0x%08h cnt=%0d", ReadData1, BusyCount);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
